// File: rtl/sample_capture_pkg.sv
// Shared types and helpers for the sample frame capture block.
package sample_capture_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        FILL      = 2'd2,
        WAIT_FREE = 2'd3
    } cap_state_e;

    localparam int OVF_W = 16;

    // RAM word width: all channels packed side by side, ch0 in the LSBs.
    function automatic int calc_w(input int ch_num, input int sample_w);
        return ch_num * sample_w;
    endfunction

    // Word address width within one bank.
    function automatic int calc_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/capture_dpram.sv
// Simple dual-port RAM holding both ping-pong banks (bank select is the
// address MSB). Synchronous write, registered read, one clock.
module capture_dpram #(
    parameter int W  = 32,
    parameter int AW = 8
) (
    input  logic          fpga_gclk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW:0]   wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW:0]   rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [0:(2**(AW+1))-1];
    logic [W-1:0] rd_data_q;

    // Write port; no reset on the array so it maps onto block RAM.
    always_ff @(posedge fpga_gclk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    // Registered read port, cleared by reset so rd_data starts at zero.
    always_ff @(posedge fpga_gclk or posedge reset) begin
        if (reset) rd_data_q <= '0;
        else       rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sample_frame_capture.sv
// Triggered frame capture into a ping-pong RAM with ready/ack read-out.
// Optional decimation is compiled in with `define SAMPLE_CAPTURE_DECIM_EN.
module sample_frame_capture
    import sample_capture_pkg::*;
#(
    parameter int CH_NUM   = 2,
    parameter int SAMPLE_W = 16,
    parameter int DEPTH    = 256,
    parameter int PERIOD   = 1048568,
    parameter int DEC_W    = 8,
    localparam int W       = calc_w(CH_NUM, SAMPLE_W),
    localparam int AW      = calc_aw(DEPTH)
) (
    input  logic             fpga_gclk,
    input  logic             reset,
    input  logic             enable,
    input  logic             s_valid,
    input  logic [W-1:0]     s_data,
    input  logic [DEC_W-1:0] dec_ratio,
    input  logic             trig_ext,
    output logic             frame_rdy,
    output logic             frame_bank,
    input  logic [AW-1:0]    rd_addr,
    output logic [W-1:0]     rd_data,
    input  logic             frame_ack,
    output logic             busy,
    output logic [OVF_W-1:0] ovf_cnt
);

    localparam int PW = $clog2(PERIOD);

    cap_state_e       state_q, state_d;
    logic             wr_bank_q, wr_bank_d;
    logic [1:0]       full_q, full_d;
    logic             frame_bank_q, frame_bank_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [PW-1:0]    per_cnt_q, per_cnt_d;

    logic period_hit, trig, free, we, fill_start, dec_keep;

    assign period_hit = enable && (per_cnt_q == PW'(PERIOD - 1));
    assign trig       = trig_ext | period_hit;
    // Banks are filled and read strictly alternately, so the presented bank
    // is always the oldest full one and is full whenever any bank is.
    assign free       = frame_ack && (|full_q);
    assign frame_rdy  = |full_q;
    assign frame_bank = frame_bank_q;
    assign busy       = (state_q == FILL);
    assign ovf_cnt    = ovf_cnt_q;

`ifdef SAMPLE_CAPTURE_DECIM_EN
    logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d, dec_last;

    assign dec_last = (dec_ratio == '0) ? '0 : dec_ratio - DEC_W'(1);
    assign dec_keep = (dec_cnt_q == '0);

    // Decimation phase: restarts on frame start, advances on every valid word.
    always_comb begin
        dec_cnt_d = dec_cnt_q;
        if (fill_start)
            dec_cnt_d = '0;
        else if (busy && s_valid)
            dec_cnt_d = (dec_cnt_q >= dec_last) ? '0 : dec_cnt_q + DEC_W'(1);
    end

    // Decimation phase register.
    always_ff @(posedge fpga_gclk or posedge reset) begin
        if (reset) dec_cnt_q <= '0;
        else       dec_cnt_q <= dec_cnt_d;
    end
`else
    logic unused_dec;
    assign unused_dec = ^dec_ratio;
    assign dec_keep   = 1'b1;
`endif

    // Free-running trigger period counter, held at zero while disabled.
    always_comb begin
        per_cnt_d = '0;
        if (enable)
            per_cnt_d = (per_cnt_q == PW'(PERIOD - 1)) ? '0 : per_cnt_q + PW'(1);
    end

    // Capture FSM, bank bookkeeping and overflow counting.
    always_comb begin
        state_d      = state_q;
        wr_bank_d    = wr_bank_q;
        full_d       = full_q;
        frame_bank_d = frame_bank_q;
        wr_addr_d    = wr_addr_q;
        ovf_cnt_d    = ovf_cnt_q;
        we           = 1'b0;
        fill_start   = 1'b0;

        // Read-side release runs regardless of enable; full banks survive an abort.
        if (free) begin
            full_d[frame_bank_q] = 1'b0;
            frame_bank_d         = ~frame_bank_q;
        end

        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = ARMED;
                ARMED: begin
                    if (trig) begin
                        state_d    = FILL;
                        fill_start = 1'b1;
                        wr_addr_d  = '0;
                    end
                end
                FILL: begin
                    if (s_valid && dec_keep) begin
                        we        = 1'b1;
                        wr_addr_d = wr_addr_q + AW'(1);
                        if (wr_addr_q == AW'(DEPTH - 1)) begin
                            full_d[wr_bank_q] = 1'b1;
                            wr_bank_d         = ~wr_bank_q;
                            // full_d already reflects a same-cycle ack.
                            state_d = full_d[~wr_bank_q] ? WAIT_FREE : ARMED;
                        end
                    end
                end
                WAIT_FREE: begin
                    if (free) begin
                        if (trig) begin
                            state_d    = FILL;
                            fill_start = 1'b1;
                            wr_addr_d  = '0;
                        end else begin
                            state_d = ARMED;
                        end
                    end else if (trig && (ovf_cnt_q != {OVF_W{1'b1}})) begin
                        ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and bookkeeping registers.
    always_ff @(posedge fpga_gclk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_bank_q    <= 1'b0;
            full_q       <= 2'b00;
            frame_bank_q <= 1'b0;
            wr_addr_q    <= '0;
            ovf_cnt_q    <= '0;
            per_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_bank_q    <= wr_bank_d;
            full_q       <= full_d;
            frame_bank_q <= frame_bank_d;
            wr_addr_q    <= wr_addr_d;
            ovf_cnt_q    <= ovf_cnt_d;
            per_cnt_q    <= per_cnt_d;
        end
    end

    capture_dpram #(.W(W), .AW(AW)) u_ram (
        .fpga_gclk (fpga_gclk),
        .reset     (reset),
        .we        (we),
        .wr_addr   ({wr_bank_q, wr_addr_q}),
        .wr_data   (s_data),
        .rd_addr   ({frame_bank_q, rd_addr}),
        .rd_data   (rd_data)
    );

endmodule

// File: tb/tb_sample_frame_capture.sv
// Directed bench for sample_frame_capture (DEPTH=8, two channels of 16 bits).
module tb_sample_frame_capture;
    import sample_capture_pkg::*;

`ifdef SAMPLE_CAPTURE_DECIM_EN
    localparam int DSTRIDE = 3;
`else
    localparam int DSTRIDE = 1;
`endif

    logic        fpga_gclk = 1'b0;
    logic        reset;
    logic        enable, s_valid, trig_ext, frame_ack;
    logic [31:0] s_data;
    logic [7:0]  dec_ratio;
    logic [2:0]  rd_addr;
    logic        frame_rdy, frame_bank, busy;
    logic [31:0] rd_data;
    logic [15:0] ovf_cnt;

    logic        enable_p;
    logic        frame_rdy_p, frame_bank_p, busy_p;
    logic [31:0] rd_data_p;
    logic [15:0] ovf_cnt_p;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 fpga_gclk = ~fpga_gclk;

    sample_frame_capture #(.CH_NUM(2), .SAMPLE_W(16), .DEPTH(8), .PERIOD(1000), .DEC_W(8)) dut (
        .fpga_gclk (fpga_gclk), .reset (reset), .enable (enable),
        .s_valid (s_valid), .s_data (s_data), .dec_ratio (dec_ratio),
        .trig_ext (trig_ext), .frame_rdy (frame_rdy), .frame_bank (frame_bank),
        .rd_addr (rd_addr), .rd_data (rd_data), .frame_ack (frame_ack),
        .busy (busy), .ovf_cnt (ovf_cnt)
    );

    // Second instance exercising the internal period trigger only.
    sample_frame_capture #(.CH_NUM(2), .SAMPLE_W(16), .DEPTH(8), .PERIOD(20), .DEC_W(8)) dut_p (
        .fpga_gclk (fpga_gclk), .reset (reset), .enable (enable_p),
        .s_valid (1'b1), .s_data (32'h0), .dec_ratio (8'd0),
        .trig_ext (1'b0), .frame_rdy (frame_rdy_p), .frame_bank (frame_bank_p),
        .rd_addr (3'd0), .rd_data (rd_data_p), .frame_ack (1'b1),
        .busy (busy_p), .ovf_cnt (ovf_cnt_p)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge fpga_gclk);
        #1;
    endtask

    // Trigger, then feed 8 consecutive words base..base+7.
    task automatic fill(input logic [31:0] base);
        trig_ext = 1'b1; step(); trig_ext = 1'b0;
        chk("fill_busy_on", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = base + i; step();
        end
        s_valid = 1'b0;
        chk("fill_busy_off", {31'd0, busy}, 32'd0);
    endtask

    task automatic read_bank(input string tag, input logic [31:0] base, input int stride);
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a); step();
            chk(tag, rd_data, base + 32'(a * stride));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int rises [3];
        int nr;
        logic prev;

        reset = 1'b1; enable = 1'b0; enable_p = 1'b0; s_valid = 1'b0; s_data = '0;
        dec_ratio = 8'd0; trig_ext = 1'b0; frame_ack = 1'b0; rd_addr = '0;
        step(); step();
        chk("rst_frame_rdy",  {31'd0, frame_rdy},  32'd0);
        chk("rst_frame_bank", {31'd0, frame_bank}, 32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_rd_data",    rd_data,             32'd0);
        chk("rst_ovf",        {16'd0, ovf_cnt},    32'd0);
        reset = 1'b0; step();
        enable = 1'b1; step();   // IDLE -> ARMED

        // Frame 0 into bank 0, data 0..7, dec_ratio=0 behaves as 1.
        trig_ext = 1'b1; step(); trig_ext = 1'b0;
        chk("t1_busy_on", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = 32'(i);
            trig_ext = (i == 3);          // ignored inside FILL
            if (i == 7) chk("t1_rdy_before_last", {31'd0, frame_rdy}, 32'd0);
            step();
        end
        s_valid = 1'b0; trig_ext = 1'b0;
        chk("t1_rdy_after_last", {31'd0, frame_rdy},  32'd1);
        chk("t1_busy_off",       {31'd0, busy},       32'd0);
        chk("t1_bank",           {31'd0, frame_bank}, 32'd0);
        chk("t1_ovf_fill_trig",  {16'd0, ovf_cnt},    32'd0);
        read_bank("t1_rd", 32'd0, 1);

        // Frame 1 into bank 1 with dec_ratio=3 on a continuous ramp.
        dec_ratio = 8'd3;
        trig_ext = 1'b1; step(); trig_ext = 1'b0;
        k = 0;
        while (busy && k < 40) begin
            s_valid = 1'b1; s_data = 32'(k); step(); k++;
        end
        s_valid = 1'b0; dec_ratio = 8'd0;
        chk("t2_words_consumed", 32'(k), 32'(8 * DSTRIDE - DSTRIDE + 1));
        chk("t2_both_full_rdy",  {31'd0, frame_rdy},  32'd1);
        chk("t2_oldest_bank",    {31'd0, frame_bank}, 32'd0);

        // Ack with both banks full: bank 1 presented next, ready stays high.
        frame_ack = 1'b1; step(); frame_ack = 1'b0;
        chk("t4_ack1_rdy",  {31'd0, frame_rdy},  32'd1);
        chk("t4_ack1_bank", {31'd0, frame_bank}, 32'd1);
        read_bank("t2_dec_rd", 32'd0, DSTRIDE);
        frame_ack = 1'b1; step(); frame_ack = 1'b0;
        chk("t4_ack2_rdy",  {31'd0, frame_rdy},  32'd0);
        chk("t4_ack2_bank", {31'd0, frame_bank}, 32'd0);
        frame_ack = 1'b1; step(); frame_ack = 1'b0;
        chk("t4_stray_ack_bank", {31'd0, frame_bank}, 32'd0);

        // Two frames without ack, then three dropped triggers.
        fill(32'h10);
        fill(32'h20);
        for (int i = 0; i < 3; i++) begin
            trig_ext = 1'b1; step(); trig_ext = 1'b0; step();
        end
        chk("t3_ovf3",      {16'd0, ovf_cnt}, 32'd3);
        chk("t3_wait_busy", {31'd0, busy},    32'd0);
        trig_ext = 1'b1; frame_ack = 1'b1; step(); trig_ext = 1'b0; frame_ack = 1'b0;
        chk("t3_ack_trig_fill", {31'd0, busy},       32'd1);
        chk("t3_ack_trig_ovf",  {16'd0, ovf_cnt},    32'd3);
        chk("t3_ack_trig_bank", {31'd0, frame_bank}, 32'd1);
        read_bank("t3_bank1_rd", 32'h20, 1);

        // Reset in the middle of a frame (after four writes).
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 32'h30 + 32'(i); step();
        end
        reset = 1'b1; #1;
        chk("t6_rst_busy",  {31'd0, busy},       32'd0);
        chk("t6_rst_rdy",   {31'd0, frame_rdy},  32'd0);
        chk("t6_rst_bank",  {31'd0, frame_bank}, 32'd0);
        chk("t6_rst_ovf",   {16'd0, ovf_cnt},    32'd0);
        chk("t6_rst_rdata", rd_data,             32'd0);
        s_valid = 1'b0; step();
        reset = 1'b0; step(); step();
        fill(32'h40);
        chk("t6_rdy",  {31'd0, frame_rdy},  32'd1);
        chk("t6_bank", {31'd0, frame_bank}, 32'd0);
        read_bank("t6_rd", 32'h40, 1);

        // Internal period trigger on the PERIOD=20 instance.
        enable_p = 1'b1; nr = 0; prev = busy_p;
        for (int c = 1; c <= 70; c++) begin
            step();
            if (busy_p && !prev && nr < 3) begin
                rises[nr] = c; nr++;
            end
            prev = busy_p;
        end
        chk("t5_rise_count", 32'(nr), 32'd3);
        chk("t5_rise0", 32'(rises[0]), 32'd20);
        chk("t5_rise1", 32'(rises[1]), 32'd40);
        chk("t5_rise2", 32'(rises[2]), 32'd60);
        chk("t5_ovf",   {16'd0, ovf_cnt_p}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
